// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: 0.01 s timebase and 4-digit BCD stopwatch (00.00..99.99)
// with start/stop, clear and lap freeze, decoded for the seven-segment driver.
module stopwatch_bcd_counter #(
  parameter int TICK_COUNT = 1_000_000,
  parameter int PRESC_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_display,
  output logic [3:0]  digit_point,
  output logic        running,
  output logic        overflow
);
  typedef enum logic {STOPPED, RUNNING} state_t;
  state_t                state;
  logic [PRESC_BITS-1:0] presc;
  logic [15:0]           digits, next_digits, lap_reg;
  logic                  frozen, tick, wrap;
  assign tick = (state == RUNNING) && (presc == PRESC_BITS'(TICK_COUNT - 1));
  assign wrap = tick && (digits == 16'h9999);
  // Carry ripples through all four digits in the tick cycle.
  always_comb begin
    logic c;
    next_digits = digits;
    c = tick;
    for (int i = 0; i < 4; i++) begin
      next_digits[4*i+:4] = c ? ((digits[4*i+:4] == 4'd9) ? 4'd0 : digits[4*i+:4] + 4'd1) : digits[4*i+:4];
      c = c && (digits[4*i+:4] == 4'd9);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= STOPPED;
      running  <= 1'b0;
      presc    <= '0;
      digits   <= '0;
      overflow <= 1'b0;
      frozen   <= 1'b0;
      lap_reg  <= '0;
    end else begin
      if (start_stop) begin
        state   <= (state == RUNNING) ? STOPPED : RUNNING;
        running <= (state != RUNNING);
      end
      if (clear) begin
        digits   <= '0;
        presc    <= '0;
        overflow <= 1'b0;
        frozen   <= 1'b0;
      end else begin
        if (state == RUNNING) presc <= tick ? '0 : presc + PRESC_BITS'(1);
        digits <= next_digits;
        if (wrap) overflow <= 1'b1;
        if (lap) begin
          frozen <= !frozen;
          if (!frozen) lap_reg <= digits;
        end
      end
    end
  end
  assign bcd_out       = frozen ? lap_reg : digits;
  assign digit_display = {(bcd_out[15:12] != 4'd0), 3'b111};
  assign digit_point   = 4'b0100;
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb_stopwatch_bcd_counter: time-in-centiseconds reference model, random and directed stimulus.
module tb_stopwatch_bcd_counter;
  localparam int T = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] bcd_out;
  logic [3:0]  digit_display, digit_point;
  logic        running, overflow;
  int tests = 0, fails = 0;
  bit m_valid = 0, m_run, m_ovf, m_frozen;
  int m_presc, m_time, m_lap;

  stopwatch_bcd_counter #(.TICK_COUNT(T), .PRESC_BITS(3)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .bcd_out(bcd_out), .digit_display(digit_display), .digit_point(digit_point),
    .running(running), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int t);
    return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: time kept as an integer count of hundredths, shown via division.
  task automatic model_update();
    bit tk;
    int old_time;
    old_time = m_time;
    if (reset) begin
      m_run = 0; m_presc = 0; m_time = 0; m_ovf = 0; m_frozen = 0; m_lap = 0; m_valid = 1;
      return;
    end
    tk = m_run && (m_presc == T - 1);
    if (m_run) m_presc = tk ? 0 : m_presc + 1;
    if (tk) begin
      if (m_time == 9999) m_ovf = 1;
      m_time = (m_time + 1) % 10000;
    end
    if (lap) begin
      if (!m_frozen) m_lap = old_time;
      m_frozen = !m_frozen;
    end
    if (clear) begin
      m_time = 0; m_presc = 0; m_ovf = 0; m_frozen = 0;
    end
    if (start_stop) m_run = !m_run;
  endtask

  task automatic compare();
    logic [15:0] e;
    if (!m_valid) return;
    e = to_bcd(m_frozen ? m_lap : m_time);
    chk("bcd_out", bcd_out, e);
    chk("digit_display", 16'(digit_display), 16'({e[15:12] != 4'd0, 3'b111}));
    chk("digit_point", 16'(digit_point), 16'h0004);
    chk("running", 16'(running), 16'(m_run));
    chk("overflow", 16'(overflow), 16'(m_ovf));
  endtask

  task automatic step(input bit ss, input bit cl, input bit lp, input bit rs);
    start_stop = ss; clear = cl; lap = lp; reset = rs;
    @(posedge clk);
    model_update();
    @(negedge clk);
    start_stop = 0; clear = 0; lap = 0; reset = 0;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_bcd", bcd_out, 16'h0000);
    chk("reset_dd", 16'(digit_display), 16'h0007);
    chk("reset_dp", 16'(digit_point), 16'h0004);
    chk("reset_run_ovf", {running, overflow}, 16'h0000);
    step(1, 0, 0, 0);
    idle(40);
    chk("run40_bcd", bcd_out, 16'h0010);
    chk("run40_running", 16'(running), 16'h0001);
    chk("run40_dd", 16'(digit_display), 16'h0007);
    step(0, 1, 0, 0);
    idle(39996);
    chk("preload_9999", bcd_out, 16'h9999);
    chk("preload_no_ovf", 16'(overflow), 16'h0000);
    idle(4);
    chk("wrap_bcd", bcd_out, 16'h0000);
    chk("wrap_ovf", 16'(overflow), 16'h0001);
    step(0, 1, 0, 0);
    chk("clear_ovf", 16'(overflow), 16'h0000);
    idle(20);
    chk("at_0005", bcd_out, 16'h0005);
    idle(1);
    step(1, 0, 0, 0);
    idle(20);
    chk("stopped_hold", bcd_out, 16'h0005);
    chk("stopped_running", 16'(running), 16'h0000);
    step(1, 0, 0, 0);
    idle(1);
    chk("resume_partial_1", bcd_out, 16'h0005);
    idle(1);
    chk("resume_partial_2", bcd_out, 16'h0006);
    idle(4);
    step(0, 0, 1, 0);
    idle(40);
    chk("lap_freeze", bcd_out, 16'h0007);
    step(0, 0, 1, 0);
    chk("lap_release", bcd_out, 16'h0017);
    step(0, 1, 0, 0);
    idle(1234 * T);
    chk("at_1234", bcd_out, 16'h1234);
    chk("dd_tens_lit", 16'(digit_display), 16'h000f);
    step(1, 1, 0, 0);
    chk("clr_ss_bcd", bcd_out, 16'h0000);
    chk("clr_ss_running", 16'(running), 16'h0000);
    step(1, 0, 0, 0);
    idle(T - 1);
    chk("presc_zero_a", bcd_out, 16'h0000);
    idle(1);
    chk("presc_zero_b", bcd_out, 16'h0001);
    idle(40 * T);
    step(0, 0, 0, 1);
    chk("midreset_bcd", bcd_out, 16'h0000);
    chk("midreset_flags", {running, overflow}, 16'h0000);
    chk("midreset_dd", 16'(digit_display), 16'h0007);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
